// File: rtl/scr_pkg.sv
// Shared types and constants for the 64b66b TX scheduler and its gearbox counter.
package scr_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int SEQ_W = 6;

    localparam logic [1:0]  HDR_DATA      = 2'b01;
    localparam logic [1:0]  HDR_CTRL      = 2'b10;
    localparam logic [63:0] IDLE_DATA_DEF = 64'h0000_0000_0000_001E;
    localparam logic [63:0] ERR_DATA_DEF  = 64'h3C78_F1E3_C78F_1E1E;

    function automatic logic hdr_legal(input logic [1:0] head);
        return (head == HDR_DATA) || (head == HDR_CTRL);
    endfunction

endpackage

// File: rtl/gbx_seq_cnt.sv
// Gearbox sequence counter: 0..SEQ_MAX with wrap, synchronous clear and a pause-slot flag.
module gbx_seq_cnt
    import scr_pkg::*;
#(
    parameter int SEQ_MAX = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [SEQ_W-1:0] o_seq,
    output logic             o_pause
);

    localparam logic [SEQ_W-1:0] LP_MAX = SEQ_W'(SEQ_MAX);

    logic [SEQ_W-1:0] r_seq;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_seq <= '0;
        end else if (i_en) begin
            r_seq <= (r_seq == LP_MAX) ? '0 : r_seq + 1'b1;
        end
    end

    assign o_seq   = r_seq;
    assign o_pause = (r_seq == LP_MAX);

endmodule

// File: rtl/scr_tx_sched.sv
// Feeds the 64b66b scrambler: startup idle burst, gearbox pause stalls,
// idle fill when upstream is empty and error-block substitution for bad headers.
module scr_tx_sched
    import scr_pkg::*;
#(
    parameter int          SEQ_MAX    = 32,
    parameter int          INIT_IDLES = 16,
    parameter logic [63:0] IDLE_DATA  = IDLE_DATA_DEF,
    parameter logic [63:0] ERR_DATA   = ERR_DATA_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gt_tx_ready_i,
    input  logic [63:0]      s_data_i,
    input  logic [1:0]       s_head_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [63:0]      scr_data_o,
    output logic [1:0]       scr_head_o,
    output logic [SEQ_W-1:0] scr_seq_o,
    output logic             scr_en_o,
    output logic             link_up_o,
    output logic [15:0]      err_cnt_o,
    output state_t           dbg_state_o
);

    localparam logic [7:0] LP_LAST_IDLE = 8'(INIT_IDLES - 1);

    state_t           r_state, w_next_state;
    logic [7:0]       r_idle_cnt;
    logic [63:0]      r_data, w_data_d;
    logic [1:0]       r_head, w_head_d;
    logic [SEQ_W-1:0] r_seq, w_seq_d;
    logic             r_en, w_en_d;
    logic             r_link;
    logic [15:0]      r_err_cnt, w_err_cnt_d;
    logic [SEQ_W-1:0] w_seq;
    logic             w_pause, w_active, w_slot, w_accept, w_legal;

    // A low TX-ready is treated exactly like WAIT in the same cycle, so nothing is accepted.
    assign w_active  = gt_tx_ready_i && (r_state != ST_WAIT);
    assign w_slot    = w_active && !w_pause;
    assign s_ready_o = (r_state == ST_RUN) && !w_pause && gt_tx_ready_i;
    assign w_accept  = s_valid_i && s_ready_o;
    assign w_legal   = hdr_legal(s_head_i);

    gbx_seq_cnt #(.SEQ_MAX(SEQ_MAX)) u_seq_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (!w_active),
        .i_en    (w_active),
        .o_seq   (w_seq),
        .o_pause (w_pause)
    );

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_WAIT: w_next_state = ST_INIT;
            ST_INIT: if (w_slot && (r_idle_cnt == LP_LAST_IDLE)) w_next_state = ST_RUN;
            ST_RUN:  w_next_state = ST_RUN;
            default: w_next_state = ST_WAIT;
        endcase
        if (!gt_tx_ready_i) w_next_state = ST_WAIT;
    end

    always_comb begin
        w_data_d    = r_data;
        w_head_d    = r_head;
        w_en_d      = 1'b0;
        w_seq_d     = '0;
        w_err_cnt_d = r_err_cnt;
        if (!w_active) begin
            w_head_d = 2'b00;
        end else begin
            w_seq_d = w_seq;
            // Pause slot leaves data/head untouched for the gearbox.
            if (!w_pause) begin
                w_en_d   = 1'b1;
                w_data_d = IDLE_DATA;
                w_head_d = HDR_CTRL;
                if (w_accept) begin
                    if (w_legal) begin
                        w_data_d = s_data_i;
                        w_head_d = s_head_i;
                    end else begin
                        w_data_d = ERR_DATA;
                        if (r_err_cnt != 16'hFFFF) w_err_cnt_d = r_err_cnt + 16'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_WAIT;
            r_idle_cnt <= '0;
            r_data     <= '0;
            r_head     <= 2'b00;
            r_seq      <= '0;
            r_en       <= 1'b0;
            r_link     <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_state   <= w_next_state;
            r_link    <= (w_next_state == ST_RUN);
            r_data    <= w_data_d;
            r_head    <= w_head_d;
            r_seq     <= w_seq_d;
            r_en      <= w_en_d;
            r_err_cnt <= w_err_cnt_d;
            if (r_state != ST_INIT) begin
                r_idle_cnt <= '0;
            end else if (w_slot) begin
                r_idle_cnt <= r_idle_cnt + 8'd1;
            end
        end
    end

    assign scr_data_o  = r_data;
    assign scr_head_o  = r_head;
    assign scr_seq_o   = r_seq;
    assign scr_en_o    = r_en;
    assign link_up_o   = r_link;
    assign err_cnt_o   = r_err_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_scr_tx_sched.sv
// Directed bench for scr_tx_sched: startup burst, pause slot, idle fill, bad headers,
// link drop and reset during INIT, with hand-computed expectations per cycle.
module tb_scr_tx_sched;
    import scr_pkg::*;

    localparam logic [63:0] IDLE  = 64'h0000_0000_0000_001E;
    localparam logic [63:0] ERR   = 64'h3C78_F1E3_C78F_1E1E;
    localparam logic [63:0] A5    = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam logic [63:0] DROPB = 64'hD00D_0000_CAFE_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        gt_tx_ready_i;
    logic [63:0] s_data_i;
    logic [1:0]  s_head_i;
    logic        s_valid_i;
    logic        s_ready_o;
    logic [63:0] scr_data_o;
    logic [1:0]  scr_head_o;
    logic [5:0]  scr_seq_o;
    logic        scr_en_o;
    logic        link_up_o;
    logic [15:0] err_cnt_o;
    state_t      dbg_state_o;

    int vectors     = 0;
    int miscompares = 0;

    scr_tx_sched dut (
        .clk           (clk),
        .rst           (rst),
        .gt_tx_ready_i (gt_tx_ready_i),
        .s_data_i      (s_data_i),
        .s_head_i      (s_head_i),
        .s_valid_i     (s_valid_i),
        .s_ready_o     (s_ready_o),
        .scr_data_o    (scr_data_o),
        .scr_head_o    (scr_head_o),
        .scr_seq_o     (scr_seq_o),
        .scr_en_o      (scr_en_o),
        .link_up_o     (link_up_o),
        .err_cnt_o     (err_cnt_o),
        .dbg_state_o   (dbg_state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] blk(input int k);
        return A5 ^ 64'(k);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one block, check ready before the edge, then check the registered outputs.
    task automatic cyc(input string tag, input logic v, input logic [63:0] d, input logic [1:0] h,
                       input logic exp_rdy, input logic exp_en, input logic [1:0] exp_head,
                       input logic [63:0] exp_data, input logic [5:0] exp_seq, input logic exp_link);
        s_valid_i = v;
        s_data_i  = d;
        s_head_i  = h;
        #1;
        chk({tag, ".ready"}, 64'(s_ready_o), 64'(exp_rdy));
        tick();
        chk({tag, ".en"},   64'(scr_en_o),   64'(exp_en));
        chk({tag, ".head"}, 64'(scr_head_o), 64'(exp_head));
        chk({tag, ".data"}, scr_data_o,      exp_data);
        chk({tag, ".seq"},  64'(scr_seq_o),  64'(exp_seq));
        chk({tag, ".link"}, 64'(link_up_o),  64'(exp_link));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; gt_tx_ready_i = 1'b1;
        s_valid_i = 1'b1; s_data_i = A5; s_head_i = 2'b01;
        repeat (3) tick();
        chk("reset.en",    64'(scr_en_o),    64'd0);
        chk("reset.head",  64'(scr_head_o),  64'd0);
        chk("reset.seq",   64'(scr_seq_o),   64'd0);
        chk("reset.data",  scr_data_o,       64'd0);
        chk("reset.link",  64'(link_up_o),   64'd0);
        chk("reset.err",   64'(err_cnt_o),   64'd0);
        chk("reset.ready", 64'(s_ready_o),   64'd0);
        chk("reset.state", 64'(dbg_state_o), 64'(ST_WAIT));

        // Startup: one WAIT cycle, then 16 idles on seq 0..15, link up with the last one.
        rst = 1'b0;
        cyc("wait", 1'b1, A5, 2'b01, 1'b0, 1'b0, 2'b00, 64'd0, 6'd0, 1'b0);
        for (int i = 0; i < 16; i++)
            cyc("init", 1'b1, A5, 2'b01, 1'b0, 1'b1, 2'b10, IDLE, 6'(i), i == 15);
        chk("run.state", 64'(dbg_state_o), 64'(ST_RUN));

        // User blocks on seq 16..31, first one is the plain A5 pattern.
        for (int k = 0; k < 16; k++)
            cyc("run", 1'b1, blk(k), 2'b01, 1'b1, 1'b1, 2'b01, blk(k), 6'(16 + k), 1'b1);

        // Pause slot: block 16 not taken, outputs hold block 15, then block 16 follows on seq 0.
        cyc("pause", 1'b1, blk(16), 2'b01, 1'b0, 1'b0, 2'b01, blk(15), 6'd32, 1'b1);
        for (int k = 16; k < 21; k++)
            cyc("wrap", 1'b1, blk(k), 2'b01, 1'b1, 1'b1, 2'b01, blk(k), 6'(k - 16), 1'b1);

        // Upstream empty for 5 cycles on seq 5..9.
        for (int i = 0; i < 5; i++)
            cyc("idle", 1'b0, blk(99), 2'b01, 1'b1, 1'b1, 2'b10, IDLE, 6'(5 + i), 1'b1);

        // Link drop at seq 10: dropped-cycle block must appear after the new INIT burst.
        gt_tx_ready_i = 1'b0;
        cyc("drop", 1'b1, DROPB, 2'b01, 1'b0, 1'b0, 2'b00, IDLE, 6'd0, 1'b0);
        gt_tx_ready_i = 1'b1;
        cyc("relock", 1'b1, DROPB, 2'b01, 1'b0, 1'b0, 2'b00, IDLE, 6'd0, 1'b0);
        for (int i = 0; i < 16; i++)
            cyc("reinit", 1'b1, DROPB, 2'b01, 1'b0, 1'b1, 2'b10, IDLE, 6'(i), i == 15);
        cyc("drop_blk", 1'b1, DROPB, 2'b01, 1'b1, 1'b1, 2'b01, DROPB, 6'd16, 1'b1);

        // Illegal headers become error blocks and are counted.
        cyc("bad00", 1'b1, 64'h1111, 2'b00, 1'b1, 1'b1, 2'b10, ERR, 6'd17, 1'b1);
        chk("bad00.err", 64'(err_cnt_o), 64'd1);
        cyc("bad11", 1'b1, 64'h2222, 2'b11, 1'b1, 1'b1, 2'b10, ERR, 6'd18, 1'b1);
        chk("bad11.err", 64'(err_cnt_o), 64'd2);

        // Saturation at FFFF.
        force dut.r_err_cnt = 16'hFFFF;
        cyc("sat_pre", 1'b1, blk(7), 2'b10, 1'b1, 1'b1, 2'b10, blk(7), 6'd19, 1'b1);
        release dut.r_err_cnt;
        chk("sat_pre.err", 64'(err_cnt_o), 64'hFFFF);
        cyc("sat", 1'b1, 64'h3333, 2'b11, 1'b1, 1'b1, 2'b10, ERR, 6'd20, 1'b1);
        chk("sat.err", 64'(err_cnt_o), 64'hFFFF);

        // Reset from RUN clears the counter, then reset again at INIT idle 7.
        rst = 1'b1;
        cyc("rst_run", 1'b1, A5, 2'b01, 1'b1, 1'b0, 2'b00, 64'd0, 6'd0, 1'b0);
        chk("rst_run.err", 64'(err_cnt_o), 64'd0);
        rst = 1'b0;
        cyc("wait2", 1'b1, A5, 2'b01, 1'b0, 1'b0, 2'b00, 64'd0, 6'd0, 1'b0);
        for (int i = 0; i < 7; i++)
            cyc("init2", 1'b1, A5, 2'b01, 1'b0, 1'b1, 2'b10, IDLE, 6'(i), 1'b0);
        rst = 1'b1;
        cyc("rst_init", 1'b1, A5, 2'b01, 1'b0, 1'b0, 2'b00, 64'd0, 6'd0, 1'b0);
        chk("rst_init.state", 64'(dbg_state_o), 64'(ST_WAIT));
        chk("rst_init.err", 64'(err_cnt_o), 64'd0);
        rst = 1'b0;
        cyc("wait3", 1'b1, A5, 2'b01, 1'b0, 1'b0, 2'b00, 64'd0, 6'd0, 1'b0);
        for (int i = 0; i < 16; i++)
            cyc("init3", 1'b1, A5, 2'b01, 1'b0, 1'b1, 2'b10, IDLE, 6'(i), i == 15);
        cyc("run3", 1'b1, A5, 2'b01, 1'b1, 1'b1, 2'b01, A5, 6'd16, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
